// File: rtl/phase_sequence_monitor.sv
//------------------------------------------------------------------------------
// phase_sequence_monitor
//
// Checks the five-phase clock set from the multi-phase PLL on the receive
// side. The phase clocks and the PLL lock flag are oversampled on i_clk_in.
// The block checks that the phases rise in strict rotation 0->1->2->3->4->0,
// measures the rotation period and reports sequence lock and faults.
//
// Ports
//   i_clk_in       system sampling clock (>= 10x phase frequency)
//   i_reset_n      synchronous active-low reset
//   i_en           monitor enable (synchronous)
//   i_ph_in[4:0]   asynchronous phase clocks, bit i = phase i*72 deg
//   i_pll_locked   asynchronous PLL lock flag
//   i_clear_fault  one-cycle pulse that clears the sticky fault
//   o_seq_locked   rotation verified stable for LOCK_ROTS rotations
//   o_fault        sticky fault flag
//   o_fault_code   1 = order error, 2 = timeout, 3 = simultaneous edges
//   o_period       last full-rotation length in i_clk_in cycles
//   o_exp_phase    index of the next expected phase (0..4)
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module phase_sequence_monitor #(
  parameter int CNT_W     = 16,
  parameter int LOCK_ROTS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic             i_clk_in,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic [4:0]       i_ph_in,
  input  logic             i_pll_locked,
  input  logic             i_clear_fault,
  output logic             o_seq_locked,
  output logic             o_fault,
  output logic [1:0]       o_fault_code,
  output logic [CNT_W-1:0] o_period,
  output logic [2:0]       o_exp_phase
);

  typedef enum logic [1:0] {IDLE, WAIT_P0, TRACK, LOCKED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [7:0]       LOCK_C    = 8'(LOCK_ROTS);

  // Bit 5 carries pll_locked, bits 4:0 the phase clocks.
  logic [5:0]       r_sync1;
  logic [5:0]       r_sync2;
  logic [5:0]       r_hist;
  logic [4:0]       r_rise;

  state_t           r_state;
  logic [2:0]       r_exp_phase;
  logic [CNT_W-1:0] r_gap;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_period;
  logic [7:0]       r_good;
  logic             r_seq_locked;
  logic             r_fault;
  logic [1:0]       r_fault_code;

  logic             w_lock;
  logic             w_go_idle;
  logic             w_multi;
  logic [4:0]       w_exp_hot;
  logic [2:0]       w_exp_next;
  logic [CNT_W-1:0] w_gap_next;
  logic [CNT_W-1:0] w_per_next;
  logic [7:0]       w_good_next;
  logic [1:0]       w_code;

  // Two-flop synchronizer plus history stage. The rise vector is registered
  // so that a phase edge and a lock-flag change take the same number of
  // edges (three) to reach the state machine.
  always_ff @(posedge i_clk_in) begin
    if (!i_reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_rise  <= '0;
    end else begin
      r_sync1 <= {i_pll_locked, i_ph_in};
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_rise  <= r_sync2[4:0] & ~r_hist[4:0];
    end
  end

  assign w_lock      = r_hist[5];
  assign w_go_idle   = !i_en || !w_lock;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi     = |(r_rise & (r_rise - 5'd1));
  assign w_exp_hot   = 5'd1 << r_exp_phase;
  assign w_exp_next  = (r_exp_phase == 3'd4) ? 3'd0 : r_exp_phase + 3'd1;
  assign w_gap_next  = (r_gap == TIMEOUT_C) ? r_gap : r_gap + CNT_W'(1);
  assign w_per_next  = (r_per == CNT_MAX) ? r_per : r_per + CNT_W'(1);
  assign w_good_next = (r_good >= LOCK_C) ? r_good : r_good + 8'd1;

  // Fault classification in priority order; only meaningful while tracking.
  // Dropping to IDLE overrides everything and never raises a fault.
  always_comb begin
    w_code = 2'd0;
    if (!w_go_idle && (r_state == TRACK || r_state == LOCKED)) begin
      if (w_multi) begin
        w_code = 2'd3;
      end else if (r_rise != 5'd0 && r_rise != w_exp_hot) begin
        w_code = 2'd1;
      end else if (r_rise == 5'd0 && w_gap_next == TIMEOUT_C) begin
        w_code = 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk_in) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_exp_phase  <= 3'd0;
      r_gap        <= '0;
      r_per        <= '0;
      r_period     <= '0;
      r_good       <= 8'd0;
      r_seq_locked <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
    end else begin
      // A fault raised this cycle wins over a simultaneous clear request.
      if (w_code != 2'd0) begin
        r_fault      <= 1'b1;
        r_fault_code <= w_code;
      end else if (i_clear_fault) begin
        r_fault      <= 1'b0;
        r_fault_code <= 2'd0;
      end

      if (w_go_idle) begin
        r_state      <= IDLE;
        r_exp_phase  <= 3'd0;
        r_gap        <= '0;
        r_per        <= '0;
        r_good       <= 8'd0;
        r_seq_locked <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= WAIT_P0;
          end
          // The first ph0 rise only starts the counters; it is not a rotation.
          WAIT_P0: begin
            if (r_rise[0]) begin
              r_state     <= TRACK;
              r_exp_phase <= 3'd1;
              r_gap       <= '0;
              r_per       <= '0;
            end
          end
          default: begin
            if (w_code != 2'd0) begin
              r_state      <= WAIT_P0;
              r_exp_phase  <= 3'd0;
              r_good       <= 8'd0;
              r_seq_locked <= 1'b0;
            end else if (r_rise == w_exp_hot) begin
              r_gap       <= '0;
              r_exp_phase <= w_exp_next;
              if (r_exp_phase == 3'd0) begin
                // The counter holds cycles since the last ph0 rise minus one.
                r_period <= w_per_next;
                r_per    <= '0;
                r_good   <= w_good_next;
                if (w_good_next == LOCK_C) begin
                  r_state      <= LOCKED;
                  r_seq_locked <= 1'b1;
                end
              end else begin
                r_per <= w_per_next;
              end
            end else begin
              r_gap <= w_gap_next;
              r_per <= w_per_next;
            end
          end
        endcase
      end
    end
  end

  assign o_seq_locked = r_seq_locked;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;
  assign o_period     = r_period;
  assign o_exp_phase  = r_exp_phase;

endmodule

// File: tb/tb_phase_sequence_monitor.sv
//------------------------------------------------------------------------------
// tb_phase_sequence_monitor
//
// Drives a programmable five-phase generator into phase_sequence_monitor and
// compares every output on every cycle against a behavioural model that keeps
// the raw input samples in a short delay line and applies the rotation rules
// directly. Directed scenarios pin the model with hand-computed values, then
// randomized episodes vary the phase period, glitches, enable, lock and clear.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_phase_sequence_monitor;

   localparam int CNT_W     = 16;
   localparam int LOCK_ROTS = 4;
   localparam int TIMEOUT   = 255;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   localparam int M_IDLE   = 0;
   localparam int M_WAIT   = 1;
   localparam int M_TRACK  = 2;
   localparam int M_LOCKED = 3;

   logic             clk = 1'b0;
   logic             rstN = 1'b0;
   logic             en = 1'b0;
   logic [4:0]       phIn = 5'd0;
   logic             pllLocked = 1'b0;
   logic             clearFault = 1'b0;
   logic             seqLocked;
   logic             fault;
   logic [1:0]       faultCode;
   logic [CNT_W-1:0] period;
   logic [2:0]       expPhase;

   phase_sequence_monitor #(
      .CNT_W(CNT_W),
      .LOCK_ROTS(LOCK_ROTS),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .i_clk_in(clk),
      .i_reset_n(rstN),
      .i_en(en),
      .i_ph_in(phIn),
      .i_pll_locked(pllLocked),
      .i_clear_fault(clearFault),
      .o_seq_locked(seqLocked),
      .o_fault(fault),
      .o_fault_code(faultCode),
      .o_period(period),
      .o_exp_phase(expPhase)
   );

   initial forever #5 clk = ~clk;

   int nCompared = 0;
   int nMismatched = 0;
   int cyc = 0;

   // Phase generator: each phase is high for one slot of genS cycles,
   // phase i starting at offset i*genS in a rotation of genP cycles.
   int genP = 50;
   int genS = 10;
   int tcnt = 0;
   int glitchPct = 0;
   bit swap23 = 1'b0;
   bit simul12 = 1'b0;
   bit freeze = 1'b0;

   // Reference model state.
   logic [5:0] smp [4];
   bit modelValid = 1'b0;
   int mMode, mExp, mGap, mPer, mGood, mPeriod, mCode;
   bit mFault, mLocked;

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual !== expected) begin
         nMismatched++;
         $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
      end
   endtask

   function automatic logic [4:0] phaseVec(input int t);
      logic [4:0] v;
      int off;
      v = '0;
      for (int i = 0; i < 5; i++) begin
         off = i * genS;
         if (swap23 && i == 2) off = 3 * genS;
         else if (swap23 && i == 3) off = 2 * genS;
         if (simul12 && i == 2) off = genS;
         v[i] = (((t + genP - off) % genP) < genS);
      end
      return v;
   endfunction

   task automatic applyStimulus(input int n);
      int idx;
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (!freeze) tcnt++;
         phIn = phaseVec(tcnt);
         if (glitchPct != 0 && $urandom_range(0, 99) < glitchPct) begin
            idx = $urandom_range(0, 4);
            phIn[idx] = ~phIn[idx];
         end
      end
   endtask

   task automatic alignTo(input int target);
      for (int i = 0; i <= genP && (tcnt % genP) != target; i++) applyStimulus(1);
   endtask

   function automatic int satCnt(input int v);
      return (v > CNT_MAX) ? CNT_MAX : v;
   endfunction

   // One model step per clock edge. An input sampled at edge n is acted on at
   // edge n+3, so the model looks three samples back for the new level and
   // four back for the previous one.
   task automatic modelStep();
      logic [4:0] rise;
      bit lk;
      int nRise, fc;
      if (!rstN) begin
         for (int i = 0; i < 4; i++) smp[i] = '0;
         mMode = M_IDLE; mExp = 0; mGap = 0; mPer = 0; mGood = 0;
         mPeriod = 0; mCode = 0; mFault = 1'b0; mLocked = 1'b0;
         modelValid = 1'b1;
      end else begin
         rise = smp[2][4:0] & ~smp[3][4:0];
         lk = smp[2][5];
         nRise = $countones(rise);
         fc = 0;
         if (!en || !lk) begin
            mMode = M_IDLE; mExp = 0; mGap = 0; mPer = 0; mGood = 0; mLocked = 1'b0;
         end else if (mMode == M_IDLE) begin
            mMode = M_WAIT;
         end else if (mMode == M_WAIT) begin
            if (rise[0]) begin
               mMode = M_TRACK; mExp = 1; mGap = 0; mPer = 0;
            end
         end else begin
            if (nRise > 1) begin
               fc = 3;
            end else if (nRise == 1 && rise[mExp] == 1'b0) begin
               fc = 1;
            end else if (nRise == 1) begin
               mGap = 0;
               if (mExp == 0) begin
                  mPeriod = satCnt(mPer + 1);
                  mPer = 0;
                  if (mGood < LOCK_ROTS) mGood++;
                  if (mGood == LOCK_ROTS) begin
                     mMode = M_LOCKED; mLocked = 1'b1;
                  end
               end else begin
                  mPer = satCnt(mPer + 1);
               end
               mExp = (mExp + 1) % 5;
            end else begin
               if (mGap < TIMEOUT) mGap++;
               mPer = satCnt(mPer + 1);
               if (mGap == TIMEOUT) fc = 2;
            end
            if (fc != 0) begin
               mMode = M_WAIT; mLocked = 1'b0; mGood = 0; mExp = 0;
            end
         end
         if (fc != 0) begin
            mFault = 1'b1; mCode = fc;
         end else if (clearFault) begin
            mFault = 1'b0; mCode = 0;
         end
         for (int i = 3; i > 0; i--) smp[i] = smp[i-1];
         smp[0] = {pllLocked, phIn};
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      modelStep();
   end

   // Every-cycle comparison, sampled on the falling edge.
   initial forever begin
      @(negedge clk);
      if (modelValid) begin
         checkOutput("cyc_seq_locked", int'(seqLocked), int'(mLocked));
         checkOutput("cyc_fault", int'(fault), int'(mFault));
         checkOutput("cyc_fault_code", int'(faultCode), mCode);
         checkOutput("cyc_period", int'(period), mPeriod);
         checkOutput("cyc_exp_phase", int'(expPhase), mExp);
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int tExp, tFault;

      // Reset state.
      applyStimulus(3);
      checkOutput("reset_seq_locked", int'(seqLocked), 0);
      checkOutput("reset_fault", int'(fault), 0);
      checkOutput("reset_code", int'(faultCode), 0);
      checkOutput("reset_period", int'(period), 0);
      checkOutput("reset_exp_phase", int'(expPhase), 0);
      rstN = 1'b1;
      en = 1'b1;
      pllLocked = 1'b1;

      // Clean rotation: period 50, spacing 10.
      $display("[TB] clean rotation");
      applyStimulus(320);
      checkOutput("clean_locked", int'(seqLocked), 1);
      checkOutput("clean_period", int'(period), 50);
      checkOutput("clean_fault", int'(fault), 0);

      // Order error: ph2/ph3 swapped for one rotation.
      $display("[TB] order error");
      alignTo(genP - 1);
      swap23 = 1'b1;
      alignTo(2 * genS);
      applyStimulus(4);
      checkOutput("order_fault", int'(fault), 1);
      checkOutput("order_code", int'(faultCode), 1);
      checkOutput("order_unlocked", int'(seqLocked), 0);
      alignTo(genP - 1);
      swap23 = 1'b0;
      applyStimulus(5 * genP + 10);
      checkOutput("order_relock", int'(seqLocked), 1);
      checkOutput("order_sticky", int'(fault), 1);
      clearFault = 1'b1;
      applyStimulus(1);
      clearFault = 1'b0;
      checkOutput("order_cleared", int'(fault), 0);
      checkOutput("order_code_cleared", int'(faultCode), 0);

      // Timeout: freeze the phases right after a ph1 rise.
      $display("[TB] timeout");
      alignTo(genS);
      freeze = 1'b1;
      tExp = -1;
      for (int i = 0; i < 20 && tExp < 0; i++) begin
         applyStimulus(1);
         if (expPhase == 3'd2) tExp = cyc;
      end
      tFault = -1;
      for (int i = 0; i < 400 && tFault < 0; i++) begin
         applyStimulus(1);
         if (faultCode == 2'd2) tFault = cyc;
      end
      checkOutput("timeout_gap", tFault - tExp, TIMEOUT);
      checkOutput("timeout_unlocked", int'(seqLocked), 0);
      freeze = 1'b0;
      applyStimulus(5 * genP + 20);
      checkOutput("timeout_relock", int'(seqLocked), 1);

      // Simultaneous ph1/ph2 edges with clear_fault on the fault cycle.
      $display("[TB] simultaneous edges");
      alignTo(genP - 1);
      simul12 = 1'b1;
      alignTo(genS);
      applyStimulus(3);
      clearFault = 1'b1;
      applyStimulus(1);
      clearFault = 1'b0;
      checkOutput("simul_fault", int'(fault), 1);
      checkOutput("simul_code", int'(faultCode), 3);
      checkOutput("simul_unlocked", int'(seqLocked), 0);
      alignTo(genP - 1);
      simul12 = 1'b0;
      applyStimulus(5 * genP + 20);
      checkOutput("simul_relock", int'(seqLocked), 1);
      clearFault = 1'b1;
      applyStimulus(1);
      clearFault = 1'b0;

      // PLL loss while locked.
      $display("[TB] pll loss");
      pllLocked = 1'b0;
      applyStimulus(3);
      checkOutput("pll_still_locked", int'(seqLocked), 1);
      applyStimulus(1);
      checkOutput("pll_idle_unlocked", int'(seqLocked), 0);
      checkOutput("pll_idle_fault", int'(fault), 0);
      checkOutput("pll_period_kept", int'(period), 50);
      checkOutput("pll_idle_exp", int'(expPhase), 0);
      pllLocked = 1'b1;
      applyStimulus(5 * genP + 20);
      checkOutput("pll_relock", int'(seqLocked), 1);

      // Reset in the middle of tracking.
      $display("[TB] reset mid-track");
      en = 1'b0;
      applyStimulus(2);
      en = 1'b1;
      applyStimulus(2 * genP);
      rstN = 1'b0;
      applyStimulus(1);
      rstN = 1'b1;
      checkOutput("rst_seq_locked", int'(seqLocked), 0);
      checkOutput("rst_fault", int'(fault), 0);
      checkOutput("rst_code", int'(faultCode), 0);
      checkOutput("rst_period", int'(period), 0);
      checkOutput("rst_exp_phase", int'(expPhase), 0);
      applyStimulus(5 * genP + 20);
      checkOutput("rst_relock", int'(seqLocked), 1);
      checkOutput("rst_relock_period", int'(period), 50);

      // Randomized episodes.
      $display("[TB] random episodes");
      for (int ep = 0; ep < 8; ep++) begin
         genS = $urandom_range(6, 14);
         genP = 5 * genS;
         glitchPct = (ep % 2 == 0) ? 0 : $urandom_range(1, 3);
         for (int c = 0; c < 600; c++) begin
            applyStimulus(1);
            clearFault = ($urandom_range(0, 99) < 2);
            en = ($urandom_range(0, 999) >= 3);
            pllLocked = ($urandom_range(0, 999) >= 3);
         end
      end
      clearFault = 1'b0;
      applyStimulus(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/phase_sequence_monitor.md
# phase_sequence_monitor

Receive-side checker for the five-phase clock set produced by the multi-phase PLL generator. The five phase clocks and the PLL lock flag are treated as asynchronous data and oversampled on a faster system clock. The block checks that the phases arrive in strict rotation 0→1→2→3→4→0, measures the rotation period, and reports sequence lock and faults to control logic.

## Interface
- CNT_W, 16: width of the gap and period counters.
- LOCK_ROTS, 4: consecutive clean rotations required before `seq_locked` asserts (1..255).
- TIMEOUT, 255: max clk_in cycles allowed between consecutive expected edges (< 2^CNT_W).

- clk_in  in  1  system sampling clock; must be ≥10× phase frequency.
- reset_n  in  1  **one clock; reset is synchronous and active-low.**
- en  in  1  monitor enable (synchronous).
- ph_in  in  5  phase clocks, bit i = phase i·72°, asynchronous.
- pll_locked  in  1  PLL lock flag, asynchronous.
- clear_fault  in  1  one-cycle pulse, clears sticky fault.
- seq_locked  out  1  rotation verified stable.
- fault  out  1  sticky fault flag.
- fault_code  out  2  1 = order error, 2 = timeout, 3 = simultaneous edges; 0 = none.
- period  out  CNT_W  last full-rotation length in clk_in cycles (ph0 rise to ph0 rise).
- exp_phase  out  3  index of the next expected phase (0..4).

## Operation
- Input path: 2-FF synchronizer per bit on ph_in and pll_locked, then one history register; rise[i] = sync2[i] & ~hist[i].
- States: IDLE, WAIT_P0, TRACK, LOCKED.
- IDLE: entered on reset, en=0, or synced pll_locked=0. Counters cleared, exp_phase=0, seq_locked=0. Leaves to WAIT_P0 when en=1 and lock=1. Entering IDLE never raises a fault.
- WAIT_P0: ignore every edge except rise[0]. On rise[0] → TRACK, exp_phase=1, gap and period counters cleared to 0. No timeout in this state.
- TRACK/LOCKED, each cycle evaluated in priority order:
  1. More than one rise bit set → fault code 3.
  2. Single rise on a bit ≠ exp_phase → fault code 1.
  3. Rise on exp_phase → gap cleared, exp_phase = (exp_phase+1) mod 5. On rise[0], period ← period counter value + 1, period counter cleared, good_rot++ (saturating at LOCK_ROTS); when good_rot reaches LOCK_ROTS, → LOCKED, seq_locked=1.
  4. No rise: gap++; gap reaching TIMEOUT → fault code 2.
- Gap counter saturates at TIMEOUT, period counter saturates at 2^CNT_W−1.
- On any fault: fault=1, fault_code updated to the code of this fault (most recent wins), seq_locked=0, good_rot=0, → WAIT_P0. Period output retains last valid value.
- clear_fault: fault=0, fault_code=0. A new fault in the same cycle wins (fault stays 1 with the new code).
- The first ph0 rise after WAIT_P0 does not count as a rotation; it only starts the counters.

## Timing
- Reset values: seq_locked=0, fault=0, fault_code=0, period=0, exp_phase=0; synchronizers and history cleared to 0.
- Latency: a ph_in transition first sampled at clk_in edge k is reflected in registered outputs after edge k+3.
- pll_locked deassertion reaches IDLE 3 edges after it is sampled. seq_locked drops on the same edge.
- All outputs are registered. There is no combinational path from any input to any output.
- seq_locked rises on the edge that registers the LOCK_ROTS-th clean ph0 rise after WAIT_P0.
- Reset mid-operation: all state returns to reset values on the next edge. A sticky fault is cleared by reset.

## Test plan
- Clean rotation: ph_in period 50 cycles, 10-cycle phase spacing, pll_locked=1, en=1 → seq_locked=1 after 4 rotations past the first ph0 (~4×50 cycles); period=50; fault=0.
- Order error: in LOCKED, swap ph2/ph3 for one rotation → fault=1, fault_code=1, seq_locked=0; recovers lock 4 clean rotations later while fault stays 1; clear_fault → fault=0, code=0.
- Timeout: freeze ph_in after a ph1 rise → fault_code=2 exactly TIMEOUT=255 cycles after the last expected edge was registered.
- Simultaneous edges: ph1 and ph2 rising in the same cycle → fault_code=3. Also pulse clear_fault on the same cycle as this fault → fault remains 1.
- PLL loss: drop pll_locked in LOCKED → IDLE after 3 cycles, seq_locked=0, fault=0, period retained. Re-assert → relock after 4 rotations.
- Reset mid-TRACK: assert reset_n=0 for one cycle → all outputs 0 on the next edge; monitor restarts from WAIT_P0 after reset release.
